// File: rtl/level_map_store_if.sv
// Port bundle for level_map_store: level load control, ROM fetch,
// tile read port and shell-hit port.
interface level_map_store_if #(
    parameter int ROWS       = 15,
    parameter int COLS       = 20,
    parameter int TILE_W     = 2,
    parameter int NUM_LEVELS = 4
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int LVL_W = $clog2(NUM_LEVELS);
    localparam int CNT_W = $clog2(ROWS*COLS+1);

    logic                   load_req;
    logic [LVL_W-1:0]       load_level;
    logic                   busy;
    logic                   load_done;
    logic                   rom_rd;
    logic [LVL_W-1:0]       rom_level;
    logic [ROW_W-1:0]       rom_row;
    logic [COLS*TILE_W-1:0] rom_data;
    logic [ROW_W-1:0]       rd_row;
    logic [COL_W-1:0]       rd_col;
    logic [TILE_W-1:0]      rd_tile;
    logic                   hit_valid;
    logic [ROW_W-1:0]       hit_row;
    logic [COL_W-1:0]       hit_col;
    logic                   hit_ack;
    logic                   hit_destroyed;
    logic [CNT_W-1:0]       bricks_left;

    modport master (
        output load_req, load_level, rom_data, rd_row, rd_col,
               hit_valid, hit_row, hit_col,
        input  busy, load_done, rom_rd, rom_level, rom_row, rd_tile,
               hit_ack, hit_destroyed, bricks_left
    );

    modport slave (
        input  load_req, load_level, rom_data, rd_row, rd_col,
               hit_valid, hit_row, hit_col,
        output busy, load_done, rom_rd, rom_level, rom_row, rd_tile,
               hit_ack, hit_destroyed, bricks_left
    );
endinterface

// File: rtl/level_map_store.sv
// Writable Battle City tile map: loads a level row by row from ROM, serves
// registered tile reads and applies shell hits with a live brick count.
module level_map_store #(
    parameter int ROWS       = 15,
    parameter int COLS       = 20,
    parameter int TILE_W     = 2,
    parameter int NUM_LEVELS = 4,
    parameter bit INDESTR_EN = 1'b1
) (
    input logic         clk,
    input logic         reset,
    level_map_store_if.slave bus
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int LVL_W = $clog2(NUM_LEVELS);
    localparam int CNT_W = $clog2(ROWS*COLS+1);
    localparam logic [TILE_W-1:0] STEEL = '1;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_e;

    state_e              state_q, state_d;
    logic [TILE_W-1:0]   tiles_q [ROWS][COLS];
    logic [LVL_W-1:0]    lvl_q, lvl_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [CNT_W-1:0]    bricks_q, bricks_d;
    logic [TILE_W-1:0]   rd_tile_q, rd_tile_d;
    logic                hit_ack_q, hit_ack_d;
    logic                hit_dest_q, hit_dest_d;

    logic                load_start, last_row, hit_take, hit_in_range, rd_in_range;
    logic [TILE_W-1:0]   hit_cur, hit_new;
    logic [TILE_W-1:0]   row_tile [COLS];
    logic [CNT_W-1:0]    row_bricks;

    function automatic logic destructible(input logic [TILE_W-1:0] v);
        return (v != '0) && (!INDESTR_EN || (v != STEEL));
    endfunction

    assign load_start   = (state_q == IDLE) && bus.load_req && (int'(bus.load_level) < NUM_LEVELS);
    assign last_row     = (int'(row_q) == ROWS-1);
    assign hit_in_range = (int'(bus.hit_row) < ROWS) && (int'(bus.hit_col) < COLS);
    assign rd_in_range  = (int'(bus.rd_row) < ROWS) && (int'(bus.rd_col) < COLS);
    // A load accepted in the same cycle pre-empts the hit.
    assign hit_take     = (state_q == IDLE) && bus.hit_valid && !load_start;
    assign hit_cur      = hit_in_range ? tiles_q[bus.hit_row][bus.hit_col] : '0;
    assign hit_new      = hit_cur - TILE_W'(1);

    always_comb begin
        row_bricks = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            row_tile[c] = bus.rom_data[(COLS-1-c)*TILE_W +: TILE_W];
            if (destructible(row_tile[c])) row_bricks = row_bricks + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_start) state_d = FETCH;
            FETCH:   state_d = WRITE;
            WRITE:   state_d = last_row ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.load_done = (state_q == DONE);
        bus.rom_rd    = (state_q == FETCH);
    end

    always_comb begin
        lvl_d      = lvl_q;
        row_d      = row_q;
        bricks_d   = bricks_q;
        hit_ack_d  = hit_take;
        hit_dest_d = 1'b0;
        rd_tile_d  = rd_in_range ? tiles_q[bus.rd_row][bus.rd_col] : '0;
        if (load_start) begin
            lvl_d    = bus.load_level;
            row_d    = '0;
            bricks_d = '0;
        end
        if (state_q == WRITE) begin
            bricks_d = bricks_q + row_bricks;
            if (!last_row) row_d = row_q + ROW_W'(1);
        end
        if (hit_take && destructible(hit_cur) && (hit_cur == TILE_W'(1))) begin
            hit_dest_d = 1'b1;
            if (bricks_q != '0) bricks_d = bricks_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_q      <= '0;
            row_q      <= '0;
            bricks_q   <= '0;
            rd_tile_q  <= '0;
            hit_ack_q  <= 1'b0;
            hit_dest_q <= 1'b0;
        end else begin
            lvl_q      <= lvl_d;
            row_q      <= row_d;
            bricks_q   <= bricks_d;
            rd_tile_q  <= rd_tile_d;
            hit_ack_q  <= hit_ack_d;
            hit_dest_q <= hit_dest_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < ROWS; r++)
                for (int unsigned c = 0; c < COLS; c++)
                    tiles_q[r][c] <= '0;
        end else if (state_q == WRITE) begin
            for (int unsigned c = 0; c < COLS; c++)
                tiles_q[row_q][c] <= row_tile[c];
        end else if (hit_take && destructible(hit_cur)) begin
            tiles_q[bus.hit_row][bus.hit_col] <= hit_new;
        end
    end

    assign bus.rom_level     = lvl_q;
    assign bus.rom_row       = row_q;
    assign bus.rd_tile       = rd_tile_q;
    assign bus.hit_ack       = hit_ack_q;
    assign bus.hit_destroyed = hit_dest_q;
    assign bus.bricks_left   = bricks_q;
endmodule

// File: tb/tb_level_map_store.sv
// Directed bench for level_map_store: load timing, reads, hits, range
// handling and load interference, against hand-computed values.
module tb_level_map_store;
    logic clk;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    level_map_store_if bus ();
    level_map_store_if #(.NUM_LEVELS(3)) bus2 ();

    level_map_store dut (.clk(clk), .reset(reset), .bus(bus.slave));
    level_map_store #(.NUM_LEVELS(3)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

    // Level ROM: even rows all 1, odd rows all 3; level 2 puts a 2 at (2,0).
    function automatic logic [39:0] rom_row_val(input int lvl, input int row);
        logic [39:0] v;
        v = (row % 2 == 1) ? {20{2'b11}} : {20{2'b01}};
        if (lvl == 2 && row == 2) v[39:38] = 2'b10;
        return v;
    endfunction

    always @(posedge clk)
        if (bus.rom_rd) bus.rom_data <= rom_row_val(int'(bus.rom_level), int'(bus.rom_row));

    task automatic do_read(input int r, input int c, output int v);
        @(negedge clk);
        bus.rd_row = 4'(r);
        bus.rd_col = 5'(c);
        @(negedge clk);
        v = int'(bus.rd_tile);
    endtask

    task automatic do_hit(input int r, input int c, output logic ack, output logic dest);
        @(negedge clk);
        bus.hit_valid = 1'b1;
        bus.hit_row   = 4'(r);
        bus.hit_col   = 5'(c);
        @(negedge clk);
        bus.hit_valid = 1'b0;
        ack  = bus.hit_ack;
        dest = bus.hit_destroyed;
    endtask

    // Runs one load, optionally injecting a hit with the request and a
    // second request plus a hit at busy cycle 5; returns observed timing.
    task automatic run_load(input int lvl, input bit inject, output int busy_cnt,
                            output int done_at, output int done_cnt, output int rd_cnt,
                            output int row_err, output int ack_cnt);
        busy_cnt = 0; done_at = 0; done_cnt = 0; rd_cnt = 0; row_err = 0; ack_cnt = 0;
        @(negedge clk);
        bus.load_req   = 1'b1;
        bus.load_level = 2'(lvl);
        if (inject) begin
            bus.hit_valid = 1'b1;
            bus.hit_row   = 4'd0;
            bus.hit_col   = 5'd5;
        end
        @(negedge clk);
        for (int i = 0; i < 80; i++) begin
            if (!bus.busy) break;
            busy_cnt++;
            if (bus.load_done) begin
                done_cnt++;
                done_at = busy_cnt;
            end
            if (bus.rom_rd) begin
                if (int'(bus.rom_row) != rd_cnt || int'(bus.rom_level) != lvl) row_err++;
                rd_cnt++;
            end
            if (bus.hit_ack) ack_cnt++;
            bus.load_req  = 1'b0;
            bus.hit_valid = 1'b0;
            if (inject && busy_cnt == 5) begin
                bus.load_req   = 1'b1;
                bus.load_level = 2'd0;
                bus.hit_valid  = 1'b1;
                bus.hit_row    = 4'd0;
                bus.hit_col    = 5'd5;
            end
            @(negedge clk);
        end
        bus.load_req  = 1'b0;
        bus.hit_valid = 1'b0;
    endtask

    task automatic test_reset();
        int v;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %0d expected 0", bus.busy); end
        vectors++; if (bus.hit_ack !== 1'b0) begin miscompares++; $display("FAIL rst_hit_ack: got %0d expected 0", bus.hit_ack); end
        vectors++; if (bus.rom_rd !== 1'b0 || bus.load_done !== 1'b0) begin miscompares++; $display("FAIL rst_rom_done: got %b%b expected 00", bus.rom_rd, bus.load_done); end
        vectors++; if (bus.bricks_left !== '0) begin miscompares++; $display("FAIL rst_bricks: got %0d expected 0", bus.bricks_left); end
        do_read(0, 0, v);
        vectors++; if (v != 0) begin miscompares++; $display("FAIL rst_rd_0_0: got %0d expected 0", v); end
        do_read(14, 19, v);
        vectors++; if (v != 0) begin miscompares++; $display("FAIL rst_rd_14_19: got %0d expected 0", v); end
    endtask

    task automatic test_load();
        int bc, da, dc, rc, re, ac, v;
        run_load(1, 1'b0, bc, da, dc, rc, re, ac);
        vectors++; if (bc != 31) begin miscompares++; $display("FAIL load_busy_cycles: got %0d expected 31", bc); end
        vectors++; if (da != 31) begin miscompares++; $display("FAIL load_done_cycle: got %0d expected 31", da); end
        vectors++; if (dc != 1) begin miscompares++; $display("FAIL load_done_pulses: got %0d expected 1", dc); end
        vectors++; if (rc != 15) begin miscompares++; $display("FAIL load_rom_rd_count: got %0d expected 15", rc); end
        vectors++; if (re != 0) begin miscompares++; $display("FAIL load_rom_addr: got %0d bad rows expected 0", re); end
        vectors++; if (int'(bus.bricks_left) != 160) begin miscompares++; $display("FAIL load_bricks: got %0d expected 160", bus.bricks_left); end
        do_read(0, 5, v);
        vectors++; if (v != 1) begin miscompares++; $display("FAIL load_rd_0_5: got %0d expected 1", v); end
        do_read(1, 5, v);
        vectors++; if (v != 3) begin miscompares++; $display("FAIL load_rd_1_5: got %0d expected 3", v); end
    endtask

    task automatic test_back_to_back();
        logic a1, d1, a2, d2, a, d;
        int b1, b2, v;
        @(negedge clk);
        bus.hit_valid = 1'b1;
        bus.hit_row   = 4'd0;
        bus.hit_col   = 5'd5;
        @(negedge clk);
        a1 = bus.hit_ack; d1 = bus.hit_destroyed; b1 = int'(bus.bricks_left);
        @(negedge clk);
        bus.hit_valid = 1'b0;
        a2 = bus.hit_ack; d2 = bus.hit_destroyed; b2 = int'(bus.bricks_left);
        vectors++; if (a1 !== 1'b1 || d1 !== 1'b1) begin miscompares++; $display("FAIL b2b_first: got ack/dest %b%b expected 11", a1, d1); end
        vectors++; if (b1 != 159) begin miscompares++; $display("FAIL b2b_bricks1: got %0d expected 159", b1); end
        vectors++; if (a2 !== 1'b1 || d2 !== 1'b0) begin miscompares++; $display("FAIL b2b_second: got ack/dest %b%b expected 10", a2, d2); end
        vectors++; if (b2 != 159) begin miscompares++; $display("FAIL b2b_bricks2: got %0d expected 159", b2); end
        do_read(0, 5, v);
        vectors++; if (v != 0) begin miscompares++; $display("FAIL b2b_tile: got %0d expected 0", v); end
        do_hit(1, 5, a, d);
        vectors++; if (a !== 1'b1 || d !== 1'b0) begin miscompares++; $display("FAIL steel_ack: got ack/dest %b%b expected 10", a, d); end
        do_read(1, 5, v);
        vectors++; if (v != 3) begin miscompares++; $display("FAIL steel_tile: got %0d expected 3", v); end
    endtask

    task automatic test_out_of_range();
        logic a, d;
        int v;
        do_hit(15, 3, a, d);
        vectors++; if (a !== 1'b1 || d !== 1'b0) begin miscompares++; $display("FAIL oor_hit: got ack/dest %b%b expected 10", a, d); end
        vectors++; if (int'(bus.bricks_left) != 159) begin miscompares++; $display("FAIL oor_bricks: got %0d expected 159", bus.bricks_left); end
        do_read(3, 20, v);
        vectors++; if (v != 0) begin miscompares++; $display("FAIL oor_read: got %0d expected 0", v); end
    endtask

    task automatic test_bad_level();
        int seen;
        seen = 0;
        @(negedge clk);
        bus2.load_req   = 1'b1;
        bus2.load_level = 2'd3;
        @(negedge clk);
        bus2.load_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus2.busy) seen++;
            @(negedge clk);
        end
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL bad_level_busy: got %0d busy cycles expected 0", seen); end
        bus2.load_req   = 1'b1;
        bus2.load_level = 2'd2;
        @(negedge clk);
        bus2.load_req = 1'b0;
        vectors++; if (bus2.busy !== 1'b1) begin miscompares++; $display("FAIL last_level_busy: got %0d expected 1", bus2.busy); end
    endtask

    task automatic test_multi_hit();
        int bc, da, dc, rc, re, ac, v;
        logic a, d;
        run_load(2, 1'b0, bc, da, dc, rc, re, ac);
        vectors++; if (int'(bus.bricks_left) != 160) begin miscompares++; $display("FAIL lvl2_bricks: got %0d expected 160", bus.bricks_left); end
        do_hit(2, 0, a, d);
        vectors++; if (a !== 1'b1 || d !== 1'b0) begin miscompares++; $display("FAIL multi_hit1: got ack/dest %b%b expected 10", a, d); end
        do_read(2, 0, v);
        vectors++; if (v != 1) begin miscompares++; $display("FAIL multi_tile1: got %0d expected 1", v); end
        vectors++; if (int'(bus.bricks_left) != 160) begin miscompares++; $display("FAIL multi_bricks1: got %0d expected 160", bus.bricks_left); end
        do_hit(2, 0, a, d);
        vectors++; if (a !== 1'b1 || d !== 1'b1) begin miscompares++; $display("FAIL multi_hit2: got ack/dest %b%b expected 11", a, d); end
        do_read(2, 0, v);
        vectors++; if (v != 0) begin miscompares++; $display("FAIL multi_tile2: got %0d expected 0", v); end
        vectors++; if (int'(bus.bricks_left) != 159) begin miscompares++; $display("FAIL multi_bricks2: got %0d expected 159", bus.bricks_left); end
    endtask

    task automatic test_read_during_hit();
        int v;
        logic d;
        @(negedge clk);
        bus.rd_row = 4'd4; bus.rd_col = 5'd0;
        bus.hit_valid = 1'b1; bus.hit_row = 4'd4; bus.hit_col = 5'd0;
        @(negedge clk);
        bus.hit_valid = 1'b0;
        v = int'(bus.rd_tile);
        d = bus.hit_destroyed;
        vectors++; if (v != 1) begin miscompares++; $display("FAIL rdhit_prehit: got %0d expected 1", v); end
        vectors++; if (d !== 1'b1) begin miscompares++; $display("FAIL rdhit_dest: got %0d expected 1", d); end
        do_read(4, 0, v);
        vectors++; if (v != 0) begin miscompares++; $display("FAIL rdhit_post: got %0d expected 0", v); end
        vectors++; if (int'(bus.bricks_left) != 158) begin miscompares++; $display("FAIL rdhit_bricks: got %0d expected 158", bus.bricks_left); end
    endtask

    task automatic test_load_interference();
        int bc, da, dc, rc, re, ac, v;
        run_load(1, 1'b1, bc, da, dc, rc, re, ac);
        vectors++; if (ac != 0) begin miscompares++; $display("FAIL intf_hit_ack: got %0d acks expected 0", ac); end
        vectors++; if (dc != 1) begin miscompares++; $display("FAIL intf_done_pulses: got %0d expected 1", dc); end
        vectors++; if (bc != 31) begin miscompares++; $display("FAIL intf_busy_cycles: got %0d expected 31", bc); end
        vectors++; if (int'(bus.bricks_left) != 160) begin miscompares++; $display("FAIL intf_bricks: got %0d expected 160", bus.bricks_left); end
        do_read(0, 5, v);
        vectors++; if (v != 1) begin miscompares++; $display("FAIL intf_tile: got %0d expected 1", v); end
    endtask

    task automatic test_reset_mid_load();
        int bc, v;
        bit hit_point;
        bc = 0;
        hit_point = 1'b0;
        @(negedge clk);
        bus.load_req   = 1'b1;
        bus.load_level = 2'd1;
        @(negedge clk);
        bus.load_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy) bc++;
            if (bc == 10) begin
                hit_point = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vectors++; if (!hit_point) begin miscompares++; $display("FAIL midrst_reach: got %0d busy cycles expected 10", bc); end
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %0d expected 0", bus.busy); end
        vectors++; if (bus.bricks_left !== '0) begin miscompares++; $display("FAIL midrst_bricks: got %0d expected 0", bus.bricks_left); end
        reset = 1'b0;
        do_read(0, 0, v);
        vectors++; if (v != 0) begin miscompares++; $display("FAIL midrst_tile_0_0: got %0d expected 0", v); end
        do_read(1, 5, v);
        vectors++; if (v != 0) begin miscompares++; $display("FAIL midrst_tile_1_5: got %0d expected 0", v); end
        repeat (3) @(negedge clk);
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_stays_idle: got %0d expected 0", bus.busy); end
    endtask

    initial begin
        reset = 1'b1;
        bus.load_req = 1'b0; bus.load_level = '0;
        bus.rd_row = '0; bus.rd_col = '0;
        bus.hit_valid = 1'b0; bus.hit_row = '0; bus.hit_col = '0;
        bus2.load_req = 1'b0; bus2.load_level = '0; bus2.rom_data = '0;
        bus2.rd_row = '0; bus2.rd_col = '0;
        bus2.hit_valid = 1'b0; bus2.hit_row = '0; bus2.hit_col = '0;
        test_reset();
        test_load();
        test_back_to_back();
        test_out_of_range();
        test_bad_level();
        test_multi_hit();
        test_read_during_hit();
        test_load_interference();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end
endmodule
